alarm_ctrl: RTL and testbench

Multi-channel alarm controller for the digital clock top level. It debounces the per-channel arm/disarm keys, keeps an armed flag per channel, detects alarm-time matches, and runs a ringing state machine. That state machine handles timeout, a stop key, queuing of simultaneous alarms and an optional snooze. It sits between the key inputs, the per-channel time comparators and the buzzer driver, and replaces the direct key-to-enable wiring used so far.

---
 rtl/alarm_pkg.sv | 15 +
 rtl/key_debounce.sv | 44 ++++
 rtl/alarm_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alarm_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: FSM state encoding and default parameters.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  localparam int unsigned DEF_N_CH           = 4;
  localparam int unsigned DEF_DEB_CYCLES     = 20000;
  localparam int unsigned DEF_RING_SECONDS   = 60;
  localparam int unsigned DEF_SNOOZE_SECONDS = 300;

endpackage

// File: rtl/key_debounce.sv
// Raw key conditioning: 2-FF synchroniser, restartable stability counter, one-cycle press on a debounced rise.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam int unsigned CNTW = $clog2(DEB_CYCLES + 1);

  logic            sync1_q, sync2_q, level_q, press_q;
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Any return to the accepted level restarts the stability count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNTW'(DEB_CYCLES - 1)) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  assign key_level = level_q;
  assign key_press = press_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Multi-channel alarm controller: key arming, match queuing and ringing FSM.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned N_CH           = DEF_N_CH,
  parameter int unsigned DEB_CYCLES     = DEF_DEB_CYCLES,
  parameter int unsigned RING_SECONDS   = DEF_RING_SECONDS
`ifdef ALARM_SNOOZE_EN
  ,
  parameter int unsigned SNOOZE_SECONDS = DEF_SNOOZE_SECONDS
`endif
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        tick_1hz,
  input  logic [N_CH-1:0]                             key_in,
  input  logic                                        key_stop,
`ifdef ALARM_SNOOZE_EN
  input  logic                                        key_snooze,
`endif
  input  logic [N_CH-1:0]                             match,
  output logic [N_CH-1:0]                             alarm_en,
  output logic                                        ringing,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ring_ch,
  output logic                                        buzzer
);

  localparam int unsigned CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned RTW = $clog2(RING_SECONDS + 1);

  logic [N_CH-1:0] key_press, alarm_en_q, alarm_en_d;
  logic [N_CH-1:0] match_s_q, match_d_q, match_rise;
  logic [N_CH-1:0] pending_q, pending_d, pend_eff, ring_mask, set_mask, clr_mask;
  logic [CW-1:0]   sel, ring_ch_q;
  logic [RTW-1:0]  ring_tmr_q;
  logic            any_pend, stop_press, cur_armed;
  logic            phase_q, ringing_q, buzzer_q;
  state_e          state_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_raw  (key_in[g]),
      .key_level(),
      .key_press(key_press[g])
    );
  end

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_stop (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_raw  (key_stop),
    .key_level(),
    .key_press(stop_press)
  );

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SW = $clog2(SNOOZE_SECONDS + 1);
  logic          snooze_press;
  logic [SW-1:0] snz_tmr_q;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_snooze (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_raw  (key_snooze),
    .key_level(),
    .key_press(snooze_press)
  );
`endif

  always_comb begin
    alarm_en_d = alarm_en_q ^ key_press;
    match_rise = match_s_q & ~match_d_q;
    ring_mask  = '0;
    if (state_q != ST_IDLE) ring_mask[ring_ch_q] = 1'b1;
    // A channel disarmed this cycle must neither be selected nor stay queued.
    pend_eff = pending_q & alarm_en_d;
    sel      = '0;
    any_pend = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (pend_eff[i] && !any_pend) begin
        sel      = CW'(i);
        any_pend = 1'b1;
      end
    end
    clr_mask = '0;
    if (state_q == ST_IDLE && any_pend) clr_mask[sel] = 1'b1;
    set_mask  = match_rise & alarm_en_q & alarm_en_d & ~ring_mask;
    pending_d = (pending_q | set_mask) & alarm_en_d & ~clr_mask;
    cur_armed = alarm_en_q[ring_ch_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      alarm_en_q <= '0;
      pending_q  <= '0;
      match_s_q  <= '0;
      match_d_q  <= '0;
      ring_ch_q  <= '0;
      ring_tmr_q <= '0;
      phase_q    <= 1'b0;
      ringing_q  <= 1'b0;
      buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_tmr_q  <= '0;
`endif
    end else begin
      alarm_en_q <= alarm_en_d;
      pending_q  <= pending_d;
      match_s_q  <= match;
      match_d_q  <= match_s_q;
      case (state_q)
        ST_IDLE: begin
          if (any_pend) begin
            state_q    <= ST_RING;
            ring_ch_q  <= sel;
            ring_tmr_q <= RTW'(1);
            phase_q    <= 1'b1;
            ringing_q  <= 1'b1;
            buzzer_q   <= 1'b1;
          end
        end
        ST_RING: begin
          if (stop_press || !cur_armed ||
              (tick_1hz && ring_tmr_q == RTW'(RING_SECONDS))) begin
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
            buzzer_q  <= 1'b0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze_press) begin
            state_q   <= ST_SNOOZE;
            snz_tmr_q <= '0;
            ringing_q <= 1'b0;
            buzzer_q  <= 1'b0;
          end
`endif
          else if (tick_1hz) begin
            ring_tmr_q <= ring_tmr_q + RTW'(1);
            phase_q    <= ~phase_q;
            buzzer_q   <= ~phase_q;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (stop_press || !cur_armed) begin
            state_q <= ST_IDLE;
          end else if (tick_1hz) begin
            if (snz_tmr_q == SW'(SNOOZE_SECONDS - 1)) begin
              state_q    <= ST_RING;
              ring_tmr_q <= RTW'(1);
              phase_q    <= 1'b1;
              ringing_q  <= 1'b1;
              buzzer_q   <= 1'b1;
            end else begin
              snz_tmr_q <= snz_tmr_q + SW'(1);
            end
          end
        end
`endif
        default: begin
          state_q   <= ST_IDLE;
          ringing_q <= 1'b0;
          buzzer_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_en = alarm_en_q;
  assign ringing  = ringing_q;
  assign ring_ch  = ring_ch_q;
  assign buzzer   = buzzer_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl (N_CH=4, DEB_CYCLES=4, RING_SECONDS=3, SNOOZE_SECONDS=2).
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, tick_1hz, key_stop, key_snooze;
  logic [3:0] key_in, match, alarm_en;
  logic       ringing, buzzer;
  logic [1:0] ring_ch;

  int checks   = 0;
  int failures = 0;

  alarm_ctrl #(
    .N_CH(4),
    .DEB_CYCLES(4),
    .RING_SECONDS(3)
`ifdef ALARM_SNOOZE_EN
    ,
    .SNOOZE_SECONDS(2)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .key_in    (key_in),
    .key_stop  (key_stop),
`ifdef ALARM_SNOOZE_EN
    .key_snooze(key_snooze),
`endif
    .match     (match),
    .alarm_en  (alarm_en),
    .ringing   (ringing),
    .ring_ch   (ring_ch),
    .buzzer    (buzzer)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
  endtask

  // Full press and release: 0..3 channel keys, 4 stop, 5 snooze.
  task automatic press_key(input int idx);
    if (idx < 4) key_in[idx] = 1'b1;
    else if (idx == 4) key_stop = 1'b1;
    else key_snooze = 1'b1;
    step(7);
    if (idx < 4) key_in[idx] = 1'b0;
    else if (idx == 4) key_stop = 1'b0;
    else key_snooze = 1'b0;
    step(7);
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; key_stop = 1'b0; key_snooze = 1'b0;
    key_in = '0; match = '0;
    #12;
    check("rst_alarm_en", alarm_en, 4'b0000);
    check("rst_ringing", ringing, 1'b0);
    check("rst_ring_ch", ring_ch, 2'd0);
    check("rst_buzzer", buzzer, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // 1. Arm toggle with bounce
    key_in[2] = 1'b1; step(1);
    key_in[2] = 1'b0; step(1);
    key_in[2] = 1'b1; step(1);
    key_in[2] = 1'b0; step(1);
    key_in[2] = 1'b1;
    step(6);
    check("arm_edge6", alarm_en, 4'b0000);
    step(1);
    check("arm_edge7", alarm_en, 4'b0100);
    key_in[2] = 1'b0; step(7);
    check("arm_release_hold", alarm_en, 4'b0100);
    press_key(2);
    check("disarm_ch2", alarm_en, 4'b0000);

    // 2. Ring and timeout
    press_key(1);
    check("arm_ch1", alarm_en, 4'b0010);
    match = 4'b0010;
    step(2);
    check("match_k1_ringing", ringing, 1'b0);
    step(1);
    check("match_k2_ringing", ringing, 1'b1);
    check("match_k2_ring_ch", ring_ch, 2'd1);
    check("buzz_entry", buzzer, 1'b1);
    tick();
    check("buzz_tick1", buzzer, 1'b0);
    check("ring_tick1", ringing, 1'b1);
    tick();
    check("buzz_tick2", buzzer, 1'b1);
    check("ring_tick2", ringing, 1'b1);
    tick();
    check("timeout_ringing", ringing, 1'b0);
    check("timeout_buzzer", buzzer, 1'b0);
    match = 4'b0000; step(2);

    // 3a. Stop press during RING
    match = 4'b0010; step(3);
    check("rering_ch1", ringing, 1'b1);
    key_stop = 1'b1;
    step(6);
    check("stop_press_cycle", ringing, 1'b1);
    step(1);
    check("stop_plus1", ringing, 1'b0);
    key_stop = 1'b0; step(7);
    match = 4'b0000; step(2);

    // 3b. Disarm mid-ring
    match = 4'b0010; step(3);
    check("ring_before_disarm", ringing, 1'b1);
    key_in[1] = 1'b1;
    step(7);
    check("disarm_alarm_en", alarm_en, 4'b0000);
    step(1);
    check("disarm_idle", ringing, 1'b0);
    key_in[1] = 1'b0; step(7);
    match = 4'b0000; step(2);

    // 3c. Unarmed match
    match = 4'b1000; step(4);
    check("unarmed_no_ring", ringing, 1'b0);
    match = 4'b0000; step(2);

    // 4. Simultaneous alarms
    for (int i = 0; i < 4; i++) press_key(i);
    check("arm_all", alarm_en, 4'b1111);
    match = 4'b1010; step(3);
    check("sim_first_ringing", ringing, 1'b1);
    check("sim_first_ch", ring_ch, 2'd1);
    key_stop = 1'b1;
    step(7);
    check("sim_stop_idle", ringing, 1'b0);
    key_stop = 1'b0;
    step(1);
    check("sim_second_ringing", ringing, 1'b1);
    check("sim_second_ch", ring_ch, 2'd3);
    step(7);
    press_key(4);
    check("sim_second_stopped", ringing, 1'b0);
    match = 4'b0000; step(2);

`ifdef ALARM_SNOOZE_EN
    // 5. Snooze
    match = 4'b0100; step(3);
    check("snz_ring", ringing, 1'b1);
    press_key(5);
    check("snz_enter", ringing, 1'b0);
    tick();
    check("snz_tick1", ringing, 1'b0);
    tick();
    check("snz_rering", ringing, 1'b1);
    check("snz_rering_ch", ring_ch, 2'd2);
    press_key(5);
    check("snz_again", ringing, 1'b0);
    press_key(4);
    tick(); tick(); tick();
    check("snz_stopped", ringing, 1'b0);
    match = 4'b0000; step(2);
`endif

    // 6. Reset mid-ring
    match = 4'b0001; step(3);
    check("pre_rst_ringing", ringing, 1'b1);
    check("pre_rst_ch", ring_ch, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ringing", ringing, 1'b0);
    check("async_rst_buzzer", buzzer, 1'b0);
    check("async_rst_alarm_en", alarm_en, 4'b0000);
    step(2);
    rst_n = 1'b1;
    step(6);
    check("post_rst_no_ring", ringing, 1'b0);
    check("post_rst_alarm_en", alarm_en, 4'b0000);
    match = 4'b0000;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
